dma_reg_sequencer: RTL and testbench
====================================

# dma_reg_sequencer

Sequencer and arbiter in front of the 16×32 register file. It shares the register file between single-cycle CPU ALU operations (add/sub) and multi-word DMA bursts between consecutive registers and memory/IO. It drives the register file's op/type/address/RegWrite controls and the memory/IO strobe handshake. It sits between the CPU control path, the DMA request port and the register file.

## Interface
Parameters:
- LEN_W, 5, width of the DMA word count (max 31 words).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- cpu_req  in  1  CPU ALU op request; held until cpu_gnt.
- cpu_sub  in  1  0 = add, 1 = sub.
- cpu_rs1, cpu_rs2, cpu_rd  in  4 each  CPU source and destination registers.
- cpu_gnt  out  1  one-cycle pulse: the op executes in this cycle.
- dma_req  in  1  DMA burst request; held until dma_busy rises.
- dma_load  in  1  1 = device→registers (lw), 0 = registers→device (sw).
- dma_type  in  2  00 = memory, 11 = IO; any other value → burst is rejected (dma_err pulse, no transfers).
- dma_reg_base  in  4  first register index.
- dma_dev_base  in  8  first device address.
- dma_len  in  LEN_W  word count.
- dma_busy  out  1  high from grant until the cycle after dma_done.
- dma_done  out  1  one-cycle completion pulse.
- dma_err  out  1  one-cycle reject pulse.
- op  out  2  register-file op (00 sw, 01 lw, 10 add, 11 sub).
- type  out  2  register-file type.
- Readreg1, Readreg2, Writereg  out  4 each  register-file ALU addresses.
- fake_source, fake_destination  out  8 each  register-file DMA register index, zero-extended.
- RegWrite  out  1  register-file write enable.
- mem_addr  out  8  device address.
- mem_rd, mem_wr  out  1 each  device strobes.
- mem_ready  in  1  device completion, sampled on clk.

## Operation
- States: IDLE, CPU_EXEC, DMA_XFER, DMA_WAIT, DMA_COMMIT, DMA_DONE.
- Idle bus value: op=00, type=01 (no-op encoding), RegWrite=0, strobes 0, all addresses 0.
- Arbitration happens in IDLE only.
  - If exactly one requester is pending, that requester wins.
  - If both are pending, the requester not served last wins. The last-served flag resets to DMA, so the CPU wins the first tie.
- CPU_EXEC lasts one cycle and returns to IDLE.
  - Drives op={1,cpu_sub}, Readreg1=cpu_rs1, Readreg2=cpu_rs2, Writereg=cpu_rd, RegWrite=1, cpu_gnt=1.
- DMA grant: latch base, len, dir and type; set dma_busy=1 and word index i=0.
  - dma_len=0 → go to DMA_DONE with no strobes.
  - Invalid type → pulse dma_err, return to IDLE, and do not raise dma_busy.
- Per word:
  - fake_source = fake_destination = {4'b0, (reg_base+i) mod 16}.
  - mem_addr = (dev_base+i) mod 256.
- Store (dma_load=0):
  - DMA_XFER for 1 cycle: op=00, type latched; the register file captures the word.
  - DMA_WAIT: mem_wr=1 with op/type held, until mem_ready is sampled high.
- Load (dma_load=1):
  - DMA_WAIT: op=01, mem_rd=1, RegWrite=0, until mem_ready.
  - DMA_COMMIT for 1 cycle: RegWrite=1, op=01, mem_rd=0.
- After each word: i==len-1 → DMA_DONE; otherwise i+1 and the next word (DMA_XFER for stores, DMA_WAIT for loads).
- DMA_DONE lasts 1 cycle: dma_done=1, then IDLE with dma_busy=0.
- A CPU request arriving during a burst waits; it is granted in the IDLE cycle following DMA_DONE.

## Timing
- Reset values: state IDLE, every output at its idle value, cpu_gnt/dma_done/dma_err/dma_busy=0, last-served=DMA, i=0.
- Reset mid-burst: strobes and RegWrite drop asynchronously. No partial-word commit occurs. The burst is lost; the requester must re-request.
- CPU latency: request seen in IDLE → cpu_gnt on the next cycle.
- DMA store word: 2 cycles plus mem_ready wait cycles. DMA load word: 1 + wait + 1 cycles.
  - Zero-wait device (mem_ready already high): N stores take 2N+1 cycles after grant, including DMA_DONE.
- mem_ready is ignored outside DMA_WAIT.
- Register index wraps: base 14, len 4 → registers 14, 15, 0, 1.
- mem_addr wraps 255 → 0.
- Lengths 17–31 revisit registers (wrap); this is legal.
- Simultaneous cpu_req and dma_req are resolved only by the last-served flag, never by the order in which the requests arrive.

## Test plan
- Reset, then cpu_req add rs1=3, rs2=4, rd=5 → cpu_gnt 1 cycle later; op=10, RegWrite=1 for exactly 1 cycle; register 5 = 7.
- DMA store base=2, dev=0x10, len=3, memory, zero-wait → mem_wr at addresses 0x10–0x12 carrying register values 2, 3, 4; dma_done at cycle 7 after grant.
- DMA load base=14, dev=0xFE, len=4, IO, 2 wait cycles per word → registers 14, 15, 0, 1 written from addresses 0xFE, 0xFF, 0x00, 0x01; RegWrite pulses exactly 4 times.
- cpu_req and dma_req asserted together after reset → CPU granted first, DMA next. Repeat the tie → DMA wins.
- Assert reset during DMA_WAIT of word 2 of 4 → mem_rd/mem_wr and dma_busy drop immediately; no RegWrite; state is IDLE.
- dma_len=0 → dma_done one cycle after grant with no strobes. dma_type=01 → dma_err pulse, dma_busy stays 0.

Source files
------------

// File: rtl/dma_reg_sequencer.sv
// dma_reg_sequencer: shares the 16x32 register file between single-cycle CPU
// add/sub operations and multi-word DMA bursts to/from memory or IO. Drives the
// register-file op/type/address/RegWrite controls and the device strobes.
//
// state      | meaning
// IDLE       | bus parked at the no-op encoding; CPU/DMA arbitration happens here
// CPU_EXEC   | one-cycle ALU add/sub, cpu_gnt high
// DMA_XFER   | store word: register file reads the current register
// DMA_WAIT   | device strobe (mem_wr for stores, mem_rd for loads) until mem_ready
// DMA_COMMIT | load word: register file writes the returned device word
// DMA_DONE   | one-cycle completion pulse; dma_busy still high
module dma_reg_sequencer #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  // CPU ALU request port
  input  logic             cpu_req,
  input  logic             cpu_sub,
  input  logic [3:0]       cpu_rs1,
  input  logic [3:0]       cpu_rs2,
  input  logic [3:0]       cpu_rd,
  output logic             cpu_gnt,
  // DMA burst request port
  input  logic             dma_req,
  input  logic             dma_load,
  input  logic [1:0]       dma_type,
  input  logic [3:0]       dma_reg_base,
  input  logic [7:0]       dma_dev_base,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_busy,
  output logic             dma_done,
  output logic             dma_err,
  // register-file controls
  output logic [1:0]       op,
  output logic [1:0]       op_type,
  output logic [3:0]       Readreg1,
  output logic [3:0]       Readreg2,
  output logic [3:0]       Writereg,
  output logic [7:0]       fake_source,
  output logic [7:0]       fake_destination,
  output logic             RegWrite,
  // device handshake
  output logic [7:0]       mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic             mem_ready
);

  localparam logic [1:0] OP_SW    = 2'b00;
  localparam logic [1:0] OP_LW    = 2'b01;
  localparam logic [1:0] TYPE_MEM = 2'b00;
  localparam logic [1:0] TYPE_NOP = 2'b01;
  localparam logic [1:0] TYPE_IO  = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU_EXEC   = 3'd1,
    DMA_XFER   = 3'd2,
    DMA_WAIT   = 3'd3,
    DMA_COMMIT = 3'd4,
    DMA_DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;

  // 1 when the CPU was the last requester served; resets to DMA-served
  logic             last_cpu;
  logic             err_q;

  logic             load_q;
  logic [1:0]       type_q;
  logic [3:0]       reg_base_q;
  logic [7:0]       dev_base_q;
  logic [LEN_W-1:0] idx_q;
  // words still to finish in this burst, counting down to the last word
  logic [LEN_W-1:0] left_q;

  logic             dma_pend;
  logic             cpu_win;
  logic             dma_win;
  logic             type_ok;
  logic             grant_dma;
  logic             reject_dma;
  logic             last_word;
  logic             word_end;
  logic [3:0]       reg_idx;
  logic [7:0]       dev_idx;

  // A rejected request is masked while its error pulse is out, so a requester
  // that is still holding dma_req sees exactly one dma_err cycle.
  assign dma_pend   = dma_req & ~err_q;
  assign cpu_win    = cpu_req & (~dma_pend | ~last_cpu);
  assign dma_win    = dma_pend & ~cpu_win;
  assign type_ok    = (dma_type == TYPE_MEM) || (dma_type == TYPE_IO);
  assign grant_dma  = (state == IDLE) && dma_win && type_ok;
  assign reject_dma = (state == IDLE) && dma_win && !type_ok;

  assign last_word  = (left_q == LEN_W'(1));
  assign reg_idx    = reg_base_q + 4'(idx_q);
  assign dev_idx    = dev_base_q + 8'(idx_q);
  assign dma_err    = err_q;

  // next-state selection and per-word completion strobe
  always_comb begin
    state_nx = state;
    word_end = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_win) begin
          state_nx = CPU_EXEC;
        end else if (grant_dma) begin
          if (dma_len == '0)
            state_nx = DMA_DONE;
          else if (dma_load)
            state_nx = DMA_WAIT;
          else
            state_nx = DMA_XFER;
        end
      end
      CPU_EXEC: state_nx = IDLE;
      DMA_XFER: state_nx = DMA_WAIT;
      DMA_WAIT: begin
        if (mem_ready) begin
          if (load_q) begin
            state_nx = DMA_COMMIT;
          end else begin
            word_end = 1'b1;
            state_nx = last_word ? DMA_DONE : DMA_XFER;
          end
        end
      end
      DMA_COMMIT: begin
        word_end = 1'b1;
        state_nx = last_word ? DMA_DONE : DMA_WAIT;
      end
      DMA_DONE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // register-file and device outputs decoded from state (reset parks them at once)
  always_comb begin
    op               = OP_SW;
    op_type          = TYPE_NOP;
    Readreg1         = 4'd0;
    Readreg2         = 4'd0;
    Writereg         = 4'd0;
    fake_source      = 8'd0;
    fake_destination = 8'd0;
    RegWrite         = 1'b0;
    mem_addr         = 8'd0;
    mem_rd           = 1'b0;
    mem_wr           = 1'b0;
    cpu_gnt          = 1'b0;
    dma_busy         = 1'b0;
    dma_done         = 1'b0;
    case (state)
      CPU_EXEC: begin
        cpu_gnt  = 1'b1;
        op       = {1'b1, cpu_sub};
        Readreg1 = cpu_rs1;
        Readreg2 = cpu_rs2;
        Writereg = cpu_rd;
        RegWrite = 1'b1;
      end
      DMA_XFER: begin
        dma_busy         = 1'b1;
        op               = OP_SW;
        op_type          = type_q;
        fake_source      = {4'b0000, reg_idx};
        fake_destination = {4'b0000, reg_idx};
        mem_addr         = dev_idx;
      end
      DMA_WAIT: begin
        dma_busy         = 1'b1;
        op               = load_q ? OP_LW : OP_SW;
        op_type          = type_q;
        fake_source      = {4'b0000, reg_idx};
        fake_destination = {4'b0000, reg_idx};
        mem_addr         = dev_idx;
        mem_rd           = load_q;
        mem_wr           = ~load_q;
      end
      DMA_COMMIT: begin
        dma_busy         = 1'b1;
        op               = OP_LW;
        op_type          = type_q;
        fake_source      = {4'b0000, reg_idx};
        fake_destination = {4'b0000, reg_idx};
        mem_addr         = dev_idx;
        RegWrite         = 1'b1;
      end
      DMA_DONE: begin
        dma_busy = 1'b1;
        dma_done = 1'b1;
      end
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // last-served flag and reject pulse, decided only in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_cpu <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= reject_dma;
      if (state == IDLE) begin
        if (cpu_win)
          last_cpu <= 1'b1;
        else if (dma_win)
          last_cpu <= 1'b0;
      end
    end
  end

  // burst context latched at grant, advanced once per completed word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q     <= 1'b0;
      type_q     <= TYPE_NOP;
      reg_base_q <= 4'd0;
      dev_base_q <= 8'd0;
      idx_q      <= '0;
      left_q     <= '0;
    end else if (grant_dma) begin
      load_q     <= dma_load;
      type_q     <= dma_type;
      reg_base_q <= dma_reg_base;
      dev_base_q <= dma_dev_base;
      idx_q      <= '0;
      left_q     <= dma_len;
    end else if (word_end) begin
      idx_q  <= idx_q + LEN_W'(1);
      left_q <= left_q - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_dma_reg_sequencer.sv
// Bench for dma_reg_sequencer: a register-file/device environment driven by the
// DUT's outputs, directed CPU vectors, hand-written arbitration/reset sequences,
// and random bursts compared against a word-list reference model.
module tb_dma_reg_sequencer;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_req, cpu_sub;
  logic [3:0]       cpu_rs1, cpu_rs2, cpu_rd;
  logic             cpu_gnt;
  logic             dma_req, dma_load;
  logic [1:0]       dma_type;
  logic [3:0]       dma_reg_base;
  logic [7:0]       dma_dev_base;
  logic [LEN_W-1:0] dma_len;
  logic             dma_busy, dma_done, dma_err;
  logic [1:0]       op, op_type;
  logic [3:0]       Readreg1, Readreg2, Writereg;
  logic [7:0]       fake_source, fake_destination;
  logic             RegWrite;
  logic [7:0]       mem_addr;
  logic             mem_rd, mem_wr;
  logic             mem_ready = 1'b0;

  dma_reg_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_sub(cpu_sub), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
    .cpu_rd(cpu_rd), .cpu_gnt(cpu_gnt),
    .dma_req(dma_req), .dma_load(dma_load), .dma_type(dma_type),
    .dma_reg_base(dma_reg_base), .dma_dev_base(dma_dev_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
    .op(op), .op_type(op_type), .Readreg1(Readreg1), .Readreg2(Readreg2),
    .Writereg(Writereg), .fake_source(fake_source), .fake_destination(fake_destination),
    .RegWrite(RegWrite), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // kind: 0 device write, 1 device read, 2 register load commit
  typedef struct {
    int         kind;
    logic [1:0] op;
    logic [1:0] typ;
    logic [7:0] idx;
    logic [7:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic        sub;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [31:0] result;
  } cpu_vec_t;

  ev_t         ev_q[$];
  int          wait_q[$];
  logic [31:0] rf  [16];
  logic [31:0] mem [256];
  logic [31:0] wdata = '0, rdata = '0;
  int checks = 0, failures = 0;
  int cyc = 0, busy_start = 0, done_cyc = 0;
  int done_n = 0, err_n = 0, bursts_n = 0, rw_n = 0;
  int wait_mode = 0, cur_w = 0, wcnt = 0;
  bit noise_en = 1'b0, have_w = 1'b0, busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nsample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check(name, {op, op_type, RegWrite, mem_rd, mem_wr, Readreg1, Readreg2, Writereg,
                 fake_source, fake_destination, mem_addr, cpu_gnt, dma_busy, dma_done, dma_err},
          {2'b00, 2'b01, 43'd0});
  endtask

  // Device + register-file environment: answers strobes after the chosen number
  // of wait cycles, toggles mem_ready randomly when no strobe is up, and logs words.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mem_rd || mem_wr) begin
      if (!have_w) begin
        cur_w  = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        wcnt   = 0;
        have_w = 1'b1;
        wait_q.push_back(cur_w);
      end
      if (wcnt == cur_w) begin
        mem_ready = 1'b1;
        have_w    = 1'b0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      have_w    = 1'b0;
      mem_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (dma_busy && !busy_prev) begin
      busy_start = cyc;
      bursts_n++;
    end
    busy_prev = dma_busy;
    if (dma_done) begin done_n++; done_cyc = cyc; end
    if (dma_err)  err_n++;
    if (RegWrite) rw_n++;
    if (dma_busy && op == 2'b00 && op_type != 2'b01 && !mem_wr)
      wdata = rf[fake_source[3:0]];
    if (mem_wr && mem_ready) begin
      mem[mem_addr] = wdata;
      ev_q.push_back('{0, op, op_type, fake_source, mem_addr, wdata});
    end
    if (mem_rd && mem_ready) begin
      rdata = mem[mem_addr];
      ev_q.push_back('{1, op, op_type, fake_destination, mem_addr, rdata});
    end
    if (RegWrite && op == 2'b01) begin
      rf[fake_destination[3:0]] = rdata;
      ev_q.push_back('{2, op, op_type, fake_destination, mem_addr, rdata});
    end
    if (RegWrite && op[1])
      rf[Writereg] = op[0] ? rf[Readreg1] - rf[Readreg2] : rf[Readreg1] + rf[Readreg2];
  end

  task automatic do_cpu(input logic sub, input logic [3:0] rs1, rs2, rd,
                        input logic [31:0] exp, input string tag);
    cpu_req = 1'b1; cpu_sub = sub; cpu_rs1 = rs1; cpu_rs2 = rs2; cpu_rd = rd;
    nsample();
    check({tag, "_no_early_gnt"}, cpu_gnt, 0);
    step();
    check({tag, "_exec_bus"}, {cpu_gnt, RegWrite, op, Readreg1, Readreg2, Writereg},
          {1'b1, 1'b1, 1'b1, sub, rs1, rs2, rd});
    cpu_req = 1'b0;
    step();
    check({tag, "_gnt_pulse"}, {cpu_gnt, RegWrite}, 2'b00);
    check({tag, "_result"}, rf[rd], exp);
  endtask

  // Reference: burst i touches register (base+i)%16 and device (dev+i)%256; each
  // word costs 2 cycles plus its wait cycles; dma_done lands after all words.
  task automatic run_dma(input bit load, input logic [1:0] typ, input logic [3:0] base,
                         input logic [7:0] dev, input int len, input int wmode, input string tag);
    ev_t         exp_q[$];
    logic [31:0] rf_s [16];
    logic [31:0] mem_s [256];
    int d0, b0, e0, r0, t, exp_cyc, r, a;
    rf_s = rf; mem_s = mem;
    ev_q.delete(); wait_q.delete();
    wait_mode = wmode;
    d0 = done_n; b0 = bursts_n; e0 = err_n; r0 = rw_n;
    dma_req = 1'b1; dma_load = load; dma_type = typ;
    dma_reg_base = base; dma_dev_base = dev; dma_len = LEN_W'(len);
    if (typ == 2'b01 || typ == 2'b10) begin
      t = 0;
      while (err_n == e0 && t < 6) begin nsample(); t++; end
      step();
      dma_req = 1'b0;
      repeat (3) step();
      check({tag, "_err_pulse"}, err_n - e0, 1);
      check({tag, "_err_no_busy"}, bursts_n - b0, 0);
      check({tag, "_err_no_done"}, done_n - d0, 0);
      check({tag, "_err_no_strobe"}, ev_q.size(), 0);
      return;
    end
    t = 0;
    while (bursts_n == b0 && t < 6) begin nsample(); t++; end
    check({tag, "_grant"}, bursts_n - b0, 1);
    step();
    dma_req = 1'b0;
    t = 0;
    while (done_n == d0 && t < 400) begin nsample(); t++; end
    check({tag, "_done_seen"}, done_n - d0, 1);
    step();
    check_idle({tag, "_idle_after"});
    for (int i = 0; i < len; i++) begin
      r = (base + i) % 16;
      a = (dev + i) % 256;
      if (load) begin
        exp_q.push_back('{1, 2'b01, typ, 8'(r), 8'(a), mem_s[a]});
        exp_q.push_back('{2, 2'b01, typ, 8'(r), 8'(a), mem_s[a]});
      end else begin
        exp_q.push_back('{0, 2'b00, typ, 8'(r), 8'(a), rf_s[r]});
      end
    end
    exp_cyc = 0;
    for (int i = 0; i < len && i < wait_q.size(); i++) exp_cyc += 2 + wait_q[i];
    check({tag, "_done_cycle"}, done_cyc - busy_start, exp_cyc);
    check({tag, "_word_count"}, ev_q.size(), exp_q.size());
    check({tag, "_regwrite_count"}, rw_n - r0, load ? len : 0);
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check({tag, "_word"}, {2'(ev_q[i].kind), ev_q[i].op, ev_q[i].typ, ev_q[i].idx, ev_q[i].addr, ev_q[i].data},
            {2'(exp_q[i].kind), exp_q[i].op, exp_q[i].typ, exp_q[i].idx, exp_q[i].addr, exp_q[i].data});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cpu_vec_t cv[6];
    int       r0, t;
    logic [3:0] rs1, rs2, rd;
    logic       sub;
    logic [31:0] exp;
    logic [1:0]  typ;

    cv[0] = '{1'b0, 4'd3,  4'd4,  4'd5,  32'd7};
    cv[1] = '{1'b1, 4'd9,  4'd2,  4'd10, 32'd7};
    cv[2] = '{1'b0, 4'd5,  4'd5,  4'd6,  32'd14};
    cv[3] = '{1'b1, 4'd1,  4'd2,  4'd11, 32'hFFFF_FFFF};
    cv[4] = '{1'b1, 4'd15, 4'd0,  4'd12, 32'd15};
    cv[5] = '{1'b0, 4'd6,  4'd10, 4'd13, 32'd21};

    for (int k = 0; k < 16; k++)  rf[k]  = 32'(k);
    for (int k = 0; k < 256; k++) mem[k] = 32'hD000_0000 + 32'(k);

    reset = 1'b1;
    cpu_req = 0; cpu_sub = 0; cpu_rs1 = 0; cpu_rs2 = 0; cpu_rd = 0;
    dma_req = 0; dma_load = 0; dma_type = 0; dma_reg_base = 0; dma_dev_base = 0; dma_len = 0;
    repeat (3) step();
    check_idle("reset_hold");
    reset = 1'b0;
    step();
    check_idle("reset_idle");

    // Tie after reset: CPU first; CPU re-requests at once, so the next tie goes to DMA.
    cpu_req = 1'b1; cpu_sub = 1'b0; cpu_rs1 = 0; cpu_rs2 = 0; cpu_rd = 0;
    dma_req = 1'b1; dma_load = 1'b0; dma_type = 2'b00; dma_len = '0;
    step();
    check("tie1_cpu_wins", {cpu_gnt, dma_busy}, 2'b10);
    step();
    check("tie2_idle", {cpu_gnt, dma_busy}, 2'b00);
    step();
    check("tie2_dma_wins", {cpu_gnt, dma_busy, dma_done}, 3'b011);
    dma_req = 1'b0;
    step();
    check("cpu_waits_burst", {cpu_gnt, dma_busy}, 2'b00);
    step();
    check("cpu_after_burst", {cpu_gnt, dma_busy}, 2'b10);
    cpu_req = 1'b0;
    step();
    check_idle("tie_idle_after");

    for (int i = 0; i < 6; i++)
      do_cpu(cv[i].sub, cv[i].rs1, cv[i].rs2, cv[i].rd, cv[i].result, "cpu_vec");

    run_dma(1'b0, 2'b00, 4'd2, 8'h10, 3, 0, "store3");
    check("store3_done_at_7", done_cyc - busy_start + 1, 7);
    check("store3_mem12", mem[8'h12], 32'd4);

    run_dma(1'b1, 2'b11, 4'd14, 8'hFE, 4, 2, "load4");
    check("load4_reg14", rf[14], 32'hD000_00FE);
    check("load4_reg1", rf[1], 32'hD000_0001);

    run_dma(1'b0, 2'b00, 4'd5, 8'h20, 0, 0, "len0");
    run_dma(1'b1, 2'b01, 4'd0, 8'h00, 4, 0, "badtype");

    // Reset while word 2 of a 4-word load waits on the device.
    wait_mode = 5;
    r0 = rw_n;
    dma_req = 1'b1; dma_load = 1'b1; dma_type = 2'b00;
    dma_reg_base = 4'd0; dma_dev_base = 8'h40; dma_len = LEN_W'(4);
    t = 0;
    while (!dma_busy && t < 6) begin nsample(); t++; end
    step();
    dma_req = 1'b0;
    t = 0;
    while (!(rw_n - r0 == 1 && mem_rd) && t < 50) begin nsample(); t++; end
    check("rst_reached_word2", {32'(rw_n - r0), mem_rd}, {32'd1, 1'b1});
    #2 reset = 1'b1;
    #1;
    check("rst_async_drop", {mem_rd, mem_wr, dma_busy, RegWrite}, 4'b0000);
    step();
    check_idle("rst_hold_idle");
    reset = 1'b0;
    step();
    check_idle("rst_released_idle");
    check("rst_no_partial_commit", rw_n - r0, 1);

    // Random mix of CPU ops and bursts with random device waits and mem_ready noise.
    noise_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sub = 1'($urandom_range(0, 1));
        rs1 = 4'($urandom_range(0, 15));
        rs2 = 4'($urandom_range(0, 15));
        rd  = 4'($urandom_range(0, 15));
        exp = sub ? rf[rs1] - rf[rs2] : rf[rs1] + rf[rs2];
        do_cpu(sub, rs1, rs2, rd, exp, "rnd_cpu");
      end else begin
        if ($urandom_range(0, 7) == 0)
          typ = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        else
          typ = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        run_dma(1'($urandom_range(0, 1)), typ, 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)), int'($urandom_range(0, 31)), -1, "rnd_dma");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
